// File: rtl/jtag_tap_target.sv
// Target-side JTAG TAP: oversamples tck/tms/tdi in the clk domain and runs the 1149.1
// controller with IDCODE, USER (FIFO bridge) and BYPASS data registers, MSB-first.
module jtag_tap_target #(
  parameter int unsigned                  DATA_INSTRUCTION = 6,
  parameter int unsigned                  DATA_FIFO        = 8,
  parameter logic [31:0]                  IDCODE           = 32'h1234_5A5B,
  parameter logic [DATA_INSTRUCTION-1:0]  OP_IDCODE        = 6'b000001,
  parameter logic [DATA_INSTRUCTION-1:0]  OP_USER          = 6'b000010
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        tck,
  input  logic                        tms,
  input  logic                        tdi,
  output logic                        tdo,
  output logic                        tdo_en,
  output logic [3:0]                  tap_state,
  output logic [DATA_INSTRUCTION-1:0] ir_value,
  output logic [DATA_FIFO-1:0]        wdata_data,
  output logic                        wr_data,
  input  logic                        full_data,
  input  logic [DATA_FIFO-1:0]        rdata_data,
  output logic                        rd_data,
  input  logic                        empty_data
);

  typedef enum logic [3:0] {
    StTlr, StRti, StSelDr, StCapDr, StShDr, StEx1Dr, StPaDr, StEx2Dr, StUpdDr,
    StSelIr, StCapIr, StShIr, StEx1Ir, StPaIr, StEx2Ir, StUpdIr
  } state_e;

  state_e                      state_q, state_d;
  logic [2:0]                  sync1_q, sync2_q;  // {tck, tms, tdi}, shared so they stay aligned
  logic                        tck_q;
  logic [DATA_INSTRUCTION-1:0] ir_sr_q;
  logic [31:0]                 idcode_sr_q;
  logic [DATA_FIFO-1:0]        user_sr_q;
  logic                        bypass_q;

  logic tck_s, tms_s, tdi_s, tck_rise, tck_fall, sel_idcode, sel_user;

  assign tck_s      = sync2_q[2];
  assign tms_s      = sync2_q[1];
  assign tdi_s      = sync2_q[0];
  assign tck_rise   = tck_s & ~tck_q;
  assign tck_fall   = ~tck_s & tck_q;
  assign sel_idcode = (ir_value == OP_IDCODE);
  assign sel_user   = (ir_value == OP_USER);
  assign tap_state  = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StTlr:   state_d = tms_s ? StTlr   : StRti;
      StRti:   state_d = tms_s ? StSelDr : StRti;
      StSelDr: state_d = tms_s ? StSelIr : StCapDr;
      StCapDr: state_d = tms_s ? StEx1Dr : StShDr;
      StShDr:  state_d = tms_s ? StEx1Dr : StShDr;
      StEx1Dr: state_d = tms_s ? StUpdDr : StPaDr;
      StPaDr:  state_d = tms_s ? StEx2Dr : StPaDr;
      StEx2Dr: state_d = tms_s ? StUpdDr : StShDr;
      StUpdDr: state_d = tms_s ? StSelDr : StRti;
      StSelIr: state_d = tms_s ? StTlr   : StCapIr;
      StCapIr: state_d = tms_s ? StEx1Ir : StShIr;
      StShIr:  state_d = tms_s ? StEx1Ir : StShIr;
      StEx1Ir: state_d = tms_s ? StUpdIr : StPaIr;
      StPaIr:  state_d = tms_s ? StEx2Ir : StPaIr;
      StEx2Ir: state_d = tms_s ? StUpdIr : StShIr;
      StUpdIr: state_d = tms_s ? StSelDr : StRti;
      default: state_d = StTlr;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StTlr;
      sync1_q     <= '0;
      sync2_q     <= '0;
      tck_q       <= 1'b0;
      ir_sr_q     <= '0;
      idcode_sr_q <= '0;
      user_sr_q   <= '0;
      bypass_q    <= 1'b0;
      ir_value    <= OP_IDCODE;
      tdo         <= 1'b0;
      tdo_en      <= 1'b0;
      wdata_data  <= '0;
      wr_data     <= 1'b0;
      rd_data     <= 1'b0;
    end else begin
      sync1_q <= {tck, tms, tdi};
      sync2_q <= sync1_q;
      tck_q   <= tck_s;
      wr_data <= 1'b0;
      rd_data <= 1'b0;
      if (tck_rise) begin
        state_q <= state_d;
        tdo_en  <= (state_d == StShIr) || (state_d == StShDr);
        // Actions belong to the state being left.
        case (state_q)
          StTlr:   ir_value <= OP_IDCODE;
          StCapIr: ir_sr_q  <= {{(DATA_INSTRUCTION-2){1'b0}}, 2'b01};
          StShIr:  ir_sr_q  <= {ir_sr_q[DATA_INSTRUCTION-2:0], tdi_s};
          StUpdIr: ir_value <= ir_sr_q;
          StCapDr: begin
            if (sel_idcode) begin
              idcode_sr_q <= IDCODE;
            end else if (sel_user) begin
              if (!empty_data) begin
                user_sr_q <= rdata_data;
                rd_data   <= 1'b1;
              end else begin
                user_sr_q <= '0;
              end
            end else begin
              bypass_q <= 1'b0;
            end
          end
          StShDr: begin
            if (sel_idcode)    idcode_sr_q <= {idcode_sr_q[30:0], tdi_s};
            else if (sel_user) user_sr_q   <= {user_sr_q[DATA_FIFO-2:0], tdi_s};
            else               bypass_q    <= tdi_s;
          end
          StUpdDr: begin
            if (sel_user && !full_data) begin
              wdata_data <= user_sr_q;
              wr_data    <= 1'b1;
            end
          end
          default: ;
        endcase
      end
      if (tck_fall) begin
        case (state_q)
          StShIr:  tdo <= ir_sr_q[DATA_INSTRUCTION-1];
          StShDr:  tdo <= sel_idcode ? idcode_sr_q[31] :
                          sel_user   ? user_sr_q[DATA_FIFO-1] : bypass_q;
          default: tdo <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jtag_tap_target.sv
// Directed bench for jtag_tap_target: drives slow tck scans and checks the TAP, IR/DR
// shifting, FIFO strobes and asynchronous reset against hand-computed values.
module tb_jtag_tap_target;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tck = 1'b0;
  logic       tms = 1'b1;
  logic       tdi = 1'b0;
  logic       tdo, tdo_en, wr_data, rd_data;
  logic [3:0] tap_state;
  logic [5:0] ir_value;
  logic [7:0] wdata_data;
  logic       full_data  = 1'b0;
  logic [7:0] rdata_data = 8'h00;
  logic       empty_data = 1'b1;

  int total = 0;
  int bad   = 0;
  int wr_cnt = 0, rd_cnt = 0, both_cnt = 0;

  jtag_tap_target dut (
    .clk        (clk),
    .rst        (rst),
    .tck        (tck),
    .tms        (tms),
    .tdi        (tdi),
    .tdo        (tdo),
    .tdo_en     (tdo_en),
    .tap_state  (tap_state),
    .ir_value   (ir_value),
    .wdata_data (wdata_data),
    .wr_data    (wr_data),
    .full_data  (full_data),
    .rdata_data (rdata_data),
    .rd_data    (rd_data),
    .empty_data (empty_data)
  );

  always #5 clk = ~clk;

  // Strobe high-cycle counters, sampled away from the active edge.
  always @(negedge clk) begin
    if (wr_data) wr_cnt <= wr_cnt + 1;
    if (rd_data) rd_cnt <= rd_cnt + 1;
    if (wr_data && rd_data) both_cnt <= both_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full tck period; returns the tdo value presented during this rise.
  task automatic tck_cycle(input logic tms_v, input logic tdi_v, output logic tdo_v);
    @(negedge clk);
    tms   = tms_v;
    tdi   = tdi_v;
    tdo_v = tdo;
    repeat (2) @(negedge clk);
    tck = 1'b1;
    repeat (4) @(negedge clk);
    tck = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // From Run-Test/Idle: load IR with v, return to Run-Test/Idle.
  task automatic load_ir(input logic [5:0] v, output logic [5:0] dout);
    logic b;
    dout = '0;
    tck_cycle(1'b1, 1'b0, b);
    tck_cycle(1'b1, 1'b0, b);
    tck_cycle(1'b0, 1'b0, b);
    tck_cycle(1'b0, 1'b0, b);
    for (int i = 5; i >= 0; i--) begin
      tck_cycle(i == 0, v[i], b);
      dout = {dout[4:0], b};
    end
    tck_cycle(1'b1, 1'b0, b);
    tck_cycle(1'b0, 1'b0, b);
  endtask

  // From Run-Test/Idle: scan n DR bits of din MSB-first, return to Run-Test/Idle.
  task automatic dr_scan(input int n, input logic [31:0] din, output logic [31:0] dout);
    logic b;
    dout = '0;
    tck_cycle(1'b1, 1'b0, b);
    tck_cycle(1'b0, 1'b0, b);
    tck_cycle(1'b0, 1'b0, b);
    for (int i = n - 1; i >= 0; i--) begin
      tck_cycle(i == 0, din[i], b);
      dout = {dout[30:0], b};
    end
    tck_cycle(1'b1, 1'b0, b);
    tck_cycle(1'b0, 1'b0, b);
  endtask

  initial begin
    logic        b;
    logic [5:0]  ir_out;
    logic [31:0] dr_out;
    int          wr0, rd0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_state", tap_state, 4'd0);
    check("rst_ir", ir_value, 6'b000001);
    check("rst_tdo", tdo, 1'b0);
    check("rst_tdo_en", tdo_en, 1'b0);
    check("rst_wr", wr_data, 1'b0);
    check("rst_rd", rd_data, 1'b0);
    check("rst_wdata", wdata_data, 8'h00);
    rst = 1'b1;

    // TAP reset by five tms=1 clocks
    repeat (5) tck_cycle(1'b1, 1'b0, b);
    check("tlr_state", tap_state, 4'd0);
    check("tlr_ir", ir_value, 6'b000001);
    check("tlr_tdo", tdo, 1'b0);

    // tck rise to tap_state latency: three clk edges
    @(negedge clk);
    tms = 1'b0;
    repeat (2) @(negedge clk);
    tck = 1'b1;
    @(negedge clk);
    check("lat_edge1", tap_state, 4'd0);
    @(negedge clk);
    check("lat_edge2", tap_state, 4'd0);
    @(negedge clk);
    check("lat_edge3", tap_state, 4'd1);
    repeat (3) @(negedge clk);
    tck = 1'b0;
    repeat (4) @(negedge clk);

    // IDCODE read
    dr_scan(32, 32'h0, dr_out);
    check("idcode_stream", dr_out, 32'h1234_5A5B);
    check("idle_state", tap_state, 4'd1);

    // IR load of USER; captured IR shifts out as 000001
    load_ir(6'b000010, ir_out);
    check("ir_capture_tdo", ir_out, 6'b000001);
    check("ir_user", ir_value, 6'b000010);

    // Shift-DR state and tdo_en
    tck_cycle(1'b1, 1'b0, b);
    tck_cycle(1'b0, 1'b0, b);
    tck_cycle(1'b0, 1'b0, b);
    check("shdr_state", tap_state, 4'd4);
    check("shdr_tdo_en", tdo_en, 1'b1);
    tck_cycle(1'b1, 1'b0, b);
    tck_cycle(1'b1, 1'b0, b);
    tck_cycle(1'b0, 1'b0, b);
    check("back_idle", tap_state, 4'd1);

    // USER write, read FIFO empty so capture loads zero
    wr0 = wr_cnt; rd0 = rd_cnt;
    full_data = 1'b0; empty_data = 1'b1;
    dr_scan(8, 32'h8E, dr_out);
    check("user_wr_pulse", wr_cnt - wr0, 1);
    check("user_wdata", wdata_data, 8'h8E);
    check("empty_no_rd", rd_cnt - rd0, 0);
    check("empty_tdo", dr_out, 32'h0);

    // USER write with full FIFO is dropped
    wr0 = wr_cnt;
    full_data = 1'b1;
    dr_scan(8, 32'h3C, dr_out);
    check("full_no_wr", wr_cnt - wr0, 0);
    check("full_wdata_kept", wdata_data, 8'h8E);

    // USER read
    wr0 = wr_cnt; rd0 = rd_cnt;
    rdata_data = 8'hA5; empty_data = 1'b0;
    dr_scan(8, 32'h0, dr_out);
    check("user_rd_pulse", rd_cnt - rd0, 1);
    check("user_rd_tdo", dr_out, 32'hA5);
    empty_data = 1'b1; full_data = 1'b0;

    // BYPASS via all-ones IR: one-tck delay
    load_ir(6'b111111, ir_out);
    check("ir_bypass", ir_value, 6'b111111);
    wr0 = wr_cnt; rd0 = rd_cnt;
    dr_scan(3, 32'b101, dr_out);
    check("bypass_tdo", dr_out, 32'b010);
    check("bypass_no_strobe", (wr_cnt - wr0) + (rd_cnt - rd0), 0);

    // Async reset mid-shift in USER Shift-DR
    load_ir(6'b000010, ir_out);
    tck_cycle(1'b1, 1'b0, b);
    tck_cycle(1'b0, 1'b0, b);
    tck_cycle(1'b0, 1'b1, b);
    tck_cycle(1'b0, 1'b1, b);
    tck_cycle(1'b0, 1'b1, b);
    check("pre_rst_shdr", tap_state, 4'd4);
    wr0 = wr_cnt; rd0 = rd_cnt;
    @(negedge clk);
    tck = 1'b1;
    #2 rst = 1'b0;
    #1;
    check("arst_state", tap_state, 4'd0);
    check("arst_ir", ir_value, 6'b000001);
    check("arst_tdo", tdo, 1'b0);
    check("arst_tdo_en", tdo_en, 1'b0);
    check("arst_wdata", wdata_data, 8'h00);
    repeat (4) @(negedge clk);
    tck = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check("arst_no_strobe", (wr_cnt - wr0) + (rd_cnt - rd0), 0);
    check("arst_hold_tlr", tap_state, 4'd0);
    check("never_both", both_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
